// File: rtl/fp_pkg.sv
// Shared types and constants for the fp_add operand-preparation stage.
package fp_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int RND_W = 3;
    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        NORM,
        ZERO,
        INF,
        NAN
    } fp_class_e;

    localparam logic [RND_W-1:0] RTNE     = 3'b000;
    localparam logic [RND_W-1:0] RTNA     = 3'b001;
    localparam logic [RND_W-1:0] INWARD   = 3'b010;
    localparam logic [RND_W-1:0] UPWARD   = 3'b011;
    localparam logic [RND_W-1:0] DOWNWARD = 3'b100;

    localparam logic [FP_W-1:0] CANON_NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [FP_W-1:0]  in1;
        logic [FP_W-1:0]  in2;
        logic [RND_W-1:0] round;
        logic             special;
        logic [FP_W-1:0]  special_res;
        logic [TAG_W-1:0] tag;
    } prep_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; subnormals are reported as ZERO.
module fp_classify
    import fp_pkg::*;
#(
    parameter int FP_WIDTH  = FP_W,
    parameter int EXP_WIDTH = EXP_W,
    parameter int MAN_WIDTH = MAN_W
) (
    input  logic [FP_WIDTH-1:0] word,
    output fp_class_e           cls,
    output logic                sign
);

    logic [EXP_WIDTH-1:0] exp_f;
    logic [MAN_WIDTH-1:0] man_f;
    logic                 exp_ones;
    logic                 exp_zero;

    assign sign     = word[FP_WIDTH-1];
    assign exp_f    = word[FP_WIDTH-2 -: EXP_WIDTH];
    assign man_f    = word[MAN_WIDTH-1:0];
    assign exp_ones = &exp_f;
    assign exp_zero = ~|exp_f;

    always_comb begin
        cls = NORM;
        unique case (1'b1)
            exp_ones && |man_f:  cls = NAN;
            exp_ones && ~|man_f: cls = INF;
            exp_zero:            cls = ZERO;
            default:             cls = NORM;
        endcase
    end

endmodule

// File: rtl/fp_add_prep.sv
// Operand preparation ahead of fp_add: special-case resolution feeding
// a 2-entry in-order buffer with registered ready and sequence tags.
module fp_add_prep
    import fp_pkg::*;
#(
    parameter int FP_WIDTH    = FP_W,
    parameter int EXP_WIDTH   = EXP_W,
    parameter int MAN_WIDTH   = MAN_W,
    parameter int ROUND_WIDTH = RND_W,
    parameter int TAG_WIDTH   = TAG_W
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [FP_WIDTH-1:0]    IN1,
    input  logic [FP_WIDTH-1:0]    IN2,
    input  logic [ROUND_WIDTH-1:0] ROUND_TYPE,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [FP_WIDTH-1:0]    OUT_IN1,
    output logic [FP_WIDTH-1:0]    OUT_IN2,
    output logic [ROUND_WIDTH-1:0] OUT_ROUND,
    output logic                   OUT_SPECIAL,
    output logic [FP_WIDTH-1:0]    OUT_SPECIAL_RES,
    output logic [TAG_WIDTH-1:0]   OUT_TAG
);

    fp_class_e cls1;
    fp_class_e cls2;
    logic      s1;
    logic      s2;

    fp_classify #(
        .FP_WIDTH (FP_WIDTH),
        .EXP_WIDTH(EXP_WIDTH),
        .MAN_WIDTH(MAN_WIDTH)
    ) u_cls1 (
        .word(IN1),
        .cls (cls1),
        .sign(s1)
    );

    fp_classify #(
        .FP_WIDTH (FP_WIDTH),
        .EXP_WIDTH(EXP_WIDTH),
        .MAN_WIDTH(MAN_WIDTH)
    ) u_cls2 (
        .word(IN2),
        .cls (cls2),
        .sign(s2)
    );

    logic                round_down;
    logic [FP_WIDTH-1:0] cancel_zero;
    logic                special;
    logic [FP_WIDTH-1:0] special_res;

    // Exact cancellation yields -0 only when rounding toward -inf.
    assign round_down  = (ROUND_TYPE == DOWNWARD);
    assign cancel_zero = {round_down, {(FP_WIDTH-1){1'b0}}};

    always_comb begin
        special     = 1'b1;
        special_res = '0;
        if (cls1 == NAN || cls2 == NAN ||
            (cls1 == INF && cls2 == INF && s1 != s2))
            special_res = CANON_NAN;
        else if (cls1 == INF)
            special_res = IN1;
        else if (cls2 == INF)
            special_res = IN2;
        else if (cls1 == ZERO && cls2 == ZERO)
            special_res = (s1 == s2) ?
                {s1, {(FP_WIDTH-1){1'b0}}} : cancel_zero;
        else if (cls1 == ZERO)
            special_res = IN2;
        else if (cls2 == ZERO)
            special_res = IN1;
        else if (IN1[FP_WIDTH-2:0] == IN2[FP_WIDTH-2:0] && s1 != s2)
            special_res = cancel_zero;
        else
            special = 1'b0;
    end

    prep_entry_t              ent0;
    prep_entry_t              ent1;
    prep_entry_t              new_ent;
    logic [1:0]               count;
    logic [1:0]               count_next;
    logic [TAG_WIDTH-1:0]     tag;
    logic                     push;
    logic                     pop;

    assign push = IN_VALID && IN_READY;
    assign pop  = OUT_VALID && OUT_READY;

    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        new_ent             = '0;
        new_ent.in1         = IN1;
        new_ent.in2         = IN2;
        new_ent.round       = ROUND_TYPE;
        new_ent.special     = special;
        new_ent.special_res = special_res;
        new_ent.tag         = tag;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ent0     <= '0;
            ent1     <= '0;
            count    <= 2'd0;
            tag      <= '0;
            IN_READY <= 1'b0;
        end else begin
            count    <= count_next;
            IN_READY <= (count_next < 2'd2);
            if (push)
                tag <= tag + 1'b1;
            // Head is always ent0; ent1 only holds the second-oldest pair.
            if (pop && count == 2'd2)
                ent0 <= ent1;
            else if (push && (count == 2'd0 || pop))
                ent0 <= new_ent;
            else if (push && count == 2'd1)
                ent1 <= new_ent;
        end
    end

    assign OUT_VALID       = (count != 2'd0);
    assign OUT_IN1         = ent0.in1;
    assign OUT_IN2         = ent0.in2;
    assign OUT_ROUND       = ent0.round;
    assign OUT_SPECIAL     = ent0.special;
    assign OUT_SPECIAL_RES = ent0.special_res;
    assign OUT_TAG         = ent0.tag;

endmodule

// File: tb/tb_fp_add_prep.sv
// Randomized and directed bench for fp_add_prep against a queue-based
// reference model of the classification rules and in-order buffer.
module tb_fp_add_prep;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] IN1 = '0;
    logic [31:0] IN2 = '0;
    logic [2:0]  ROUND_TYPE = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] OUT_IN1;
    logic [31:0] OUT_IN2;
    logic [2:0]  OUT_ROUND;
    logic        OUT_SPECIAL;
    logic [31:0] OUT_SPECIAL_RES;
    logic [3:0]  OUT_TAG;

    fp_add_prep dut (
        .CLK            (CLK),
        .RST            (RST),
        .IN_VALID       (IN_VALID),
        .IN_READY       (IN_READY),
        .IN1            (IN1),
        .IN2            (IN2),
        .ROUND_TYPE     (ROUND_TYPE),
        .OUT_VALID      (OUT_VALID),
        .OUT_READY      (OUT_READY),
        .OUT_IN1        (OUT_IN1),
        .OUT_IN2        (OUT_IN2),
        .OUT_ROUND      (OUT_ROUND),
        .OUT_SPECIAL    (OUT_SPECIAL),
        .OUT_SPECIAL_RES(OUT_SPECIAL_RES),
        .OUT_TAG        (OUT_TAG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rt;
        logic        sp;
        logic [31:0] res;
        logic [3:0]  tag;
    } exp_t;

    exp_t       q[$];
    logic       m_rdy = 1'b0;
    logic       m_rst = 1'b1;
    logic [3:0] m_tag = '0;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // 0 normal, 1 zero/subnormal, 2 infinity, 3 NaN
    function automatic int fclass(logic [31:0] x);
        int e = int'(x[30:23]);
        int m = int'(x[22:0]);
        if (e == 255) return (m != 0) ? 3 : 2;
        if (e == 0) return 1;
        return 0;
    endfunction

    function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                   logic [2:0] rt, logic [3:0] tg);
        exp_t r;
        int ca = fclass(a);
        int cb = fclass(b);
        logic [31:0] opp_zero = (rt == 3'd4) ? 32'h8000_0000 : 32'h0;
        bit opposite = (a[31] != b[31]);
        r.a = a; r.b = b; r.rt = rt; r.tag = tg;
        r.sp = 1'b1; r.res = 32'h0;
        if (ca == 3 || cb == 3 || (ca == 2 && cb == 2 && opposite))
            r.res = 32'h7FC0_0000;
        else if (ca == 2) r.res = a;
        else if (cb == 2) r.res = b;
        else if (ca == 1 && cb == 1)
            r.res = opposite ? opp_zero : (a[31] ? 32'h8000_0000 : 32'h0);
        else if (ca == 1) r.res = b;
        else if (cb == 1) r.res = a;
        else if (opposite && (a ^ b) == 32'h8000_0000) r.res = opp_zero;
        else r.sp = 1'b0;
        return r;
    endfunction

    // Called at a falling edge: drive, check current state, advance model.
    task automatic step(input logic rst, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] rt,
                        input logic ordy);
        exp_t h;
        RST = rst; IN_VALID = v; IN1 = a; IN2 = b;
        ROUND_TYPE = rt; OUT_READY = ordy;
        #1;
        check("in_ready", 32'(IN_READY), 32'(m_rdy));
        check("out_valid", 32'(OUT_VALID), 32'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
            check("out_in1", OUT_IN1, h.a);
            check("out_in2", OUT_IN2, h.b);
            check("out_round", 32'(OUT_ROUND), 32'(h.rt));
            check("out_special", 32'(OUT_SPECIAL), 32'(h.sp));
            if (h.sp) check("special_res", OUT_SPECIAL_RES, h.res);
            check("out_tag", 32'(OUT_TAG), 32'(h.tag));
        end else if (m_rst) begin
            check("rst_data", OUT_IN1 | OUT_IN2 | OUT_SPECIAL_RES, 32'h0);
            check("rst_tag", 32'(OUT_TAG), 32'h0);
        end
        if (rst) begin
            q.delete();
            m_tag = '0;
            m_rdy = 1'b0;
            m_rst = 1'b1;
        end else begin
            bit push = v && m_rdy;
            bit pop  = (q.size() != 0) && ordy;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(model(a, b, rt, m_tag));
                m_tag++;
            end
            m_rdy = (q.size() < 2);
            m_rst = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, ordy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        idle(1'b0);
    endtask

    function automatic logic [31:0] rand_op(logic [31:0] other);
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 7))
            0: return {r[31], 31'h0};
            1: return {r[31], 8'h00, r[22:0]};
            2: return {r[31], 8'hFF, 23'h0};
            3: return {r[31], 8'hFF, r[22:1], 1'b1};
            4: return {~other[31], other[30:0]};
            5: return other;
            default: return r;
        endcase
    endfunction

    initial begin
        @(negedge CLK);
        do_reset();
        check("ready_after_rst", 32'(IN_READY), 32'h1);

        step(1'b0, 1'b1, 32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b1);
        check("d_norm_special", 32'(OUT_SPECIAL), 32'h0);
        check("d_norm_tag", 32'(OUT_TAG), 32'h0);
        check("d_norm_in1", OUT_IN1, 32'h3F80_0000);
        check("d_norm_ready", 32'(IN_READY), 32'h1);

        step(1'b0, 1'b1, 32'h7F80_0000, 32'hFF80_0000, 3'd0, 1'b1);
        check("d_inf_nan", OUT_SPECIAL_RES, 32'h7FC0_0000);
        step(1'b0, 1'b1, 32'h7F80_0000, 32'h3F80_0000, 3'd0, 1'b1);
        check("d_inf", OUT_SPECIAL_RES, 32'h7F80_0000);
        step(1'b0, 1'b1, 32'h3FC0_0000, 32'hBFC0_0000, 3'd0, 1'b1);
        check("d_cancel_rtne", OUT_SPECIAL_RES, 32'h0000_0000);
        step(1'b0, 1'b1, 32'h3FC0_0000, 32'hBFC0_0000, 3'd4, 1'b1);
        check("d_cancel_down", OUT_SPECIAL_RES, 32'h8000_0000);
        step(1'b0, 1'b1, 32'h0000_0001, 32'h4040_0000, 3'd0, 1'b1);
        check("d_subnorm", OUT_SPECIAL_RES, 32'h4040_0000);
        check("d_subnorm_sp", 32'(OUT_SPECIAL), 32'h1);
        idle(1'b1);

        do_reset();
        step(1'b0, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 1'b0);
        step(1'b0, 1'b1, 32'h4000_0000, 32'h4000_0000, 3'd0, 1'b0);
        check("bp_ready_low", 32'(IN_READY), 32'h0);
        step(1'b0, 1'b1, 32'h4040_0000, 32'h4040_0000, 3'd0, 1'b0);
        step(1'b0, 1'b1, 32'h4040_0000, 32'h4040_0000, 3'd0, 1'b0);
        check("bp_head_stable", OUT_IN1, 32'h3F80_0000);
        step(1'b0, 1'b1, 32'h4040_0000, 32'h4040_0000, 3'd0, 1'b1);
        check("bp_tag1", 32'(OUT_TAG), 32'h1);
        check("bp_ready_back", 32'(IN_READY), 32'h1);
        step(1'b0, 1'b1, 32'h4040_0000, 32'h4040_0000, 3'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        do_reset();
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b1, $urandom, $urandom, 3'd0, 1'b1);
        check("wrap_tag", 32'(OUT_TAG), 32'h0);
        idle(1'b1);
        step(1'b0, 1'b1, 32'h3F80_0000, 32'h0, 3'd1, 1'b0);
        step(1'b0, 1'b1, 32'h3F80_0000, 32'h0, 3'd1, 1'b0);
        check("hold_full", 32'(IN_READY), 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        check("rst_valid", 32'(OUT_VALID), 32'h0);
        check("rst_ready", 32'(IN_READY), 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        step(1'b0, 1'b1, 32'h4000_0000, 32'h3F80_0000, 3'd2, 1'b1);
        check("rst_tag_restart", 32'(OUT_TAG), 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] a = rand_op($urandom);
            logic [31:0] b = rand_op(a);
            logic        v = ($urandom_range(0, 3) != 0);
            logic        r = ($urandom_range(0, 9) < 6);
            logic        x = ($urandom_range(0, 199) == 0);
            step(x, v, a, b, 3'($urandom_range(0, 7)), r);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
